fetch_redirect_ctrl: RTL

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

---
 rtl/fetch_redirect_ctrl_pkg.sv | 31 +++
 rtl/redirect_prio_enc.sv | 25 ++
 rtl/fetch_redirect_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
package fetch_redirect_ctrl_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h1c00_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        IDLE = 2'd3
    } state_e;

    // Ordered so that a numerically larger class always wins.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        PD   = 2'd1,
        EX   = 2'd2,
        EXCP = 2'd3
    } prio_e;

    typedef struct packed {
        prio_e           cls;
        logic [PC_W-1:0] pc;
    } redirect_t;

    function automatic logic prio_ge(input prio_e a, input prio_e b);
        return a >= b;
    endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Fixed-priority select among the three redirect sources: exception > EX branch > predecode.
module redirect_prio_enc
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic            excp_req,
    input  logic [PC_W-1:0] excp_pc,
    input  logic            ex_br,
    input  logic [PC_W-1:0] ex_br_pc,
    input  logic            pd_br,
    input  logic [PC_W-1:0] pd_pc,
    output redirect_t       win
);

    always_comb begin
        win = '{cls: NONE, pc: '0};
        if (excp_req) begin
            win = '{cls: EXCP, pc: excp_pc};
        end else if (ex_br) begin
            win = '{cls: EX, pc: ex_br_pc};
        end else if (pd_br) begin
            win = '{cls: PD, pc: pd_pc};
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect arbiter: picks the PC-select redirect, holds it while the
// ICache is busy, drives wrong-path flushes, fetch enable and the redirect epoch.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned EPOCH_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               excp_req,
    input  logic [PC_W-1:0]    excp_pc,
    input  logic               ex_br,
    input  logic [PC_W-1:0]    ex_br_pc,
    input  logic               pd_br,
    input  logic [PC_W-1:0]    pd_pc,
    input  logic               idle_req,
    input  logic               intr_pending,
    input  logic               icache_busy,
    input  logic               ib_full,
    output logic               redirect_valid,
    output logic [PC_W-1:0]    redirect_pc,
    output logic               flush_front,
    output logic               flush_back,
    output logic               fetch_en,
    output logic [EPOCH_W-1:0] epoch
);

    state_e    state, state_nx;
    redirect_t pend, pend_nx;
    redirect_t win;
    redirect_t merged;
    logic      any_req;
    logic      take_new;

    redirect_prio_enc u_prio_enc (
        .excp_req (excp_req),
        .excp_pc  (excp_pc),
        .ex_br    (ex_br),
        .ex_br_pc (ex_br_pc),
        .pd_br    (pd_br),
        .pd_pc    (pd_pc),
        .win      (win)
    );

    assign any_req  = excp_req | ex_br | pd_br;
    // Equal class replaces the held request: the younger target is the live one.
    assign take_new = (win.cls != NONE) && prio_ge(win.cls, pend.cls);
    assign merged   = take_new ? win : pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pend  <= '{cls: NONE, pc: '0};
            epoch <= '0;
        end else begin
            state <= state_nx;
            pend  <= pend_nx;
            epoch <= epoch + EPOCH_W'(redirect_valid);
        end
    end

    always_comb begin
        state_nx       = state;
        pend_nx        = pend;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush_front    = any_req;
        flush_back     = excp_req | ex_br;
        fetch_en       = 1'b0;

        case (state)
            BOOT: begin
                redirect_valid = 1'b1;
                redirect_pc    = RESET_PC;
                state_nx       = RUN;
            end
            RUN: begin
                fetch_en = ~icache_busy & ~ib_full & ~any_req;
                if (win.cls != NONE) begin
                    if (!icache_busy) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = win.pc;
                    end else begin
                        pend_nx  = win;
                        state_nx = PEND;
                    end
                end else if (idle_req) begin
                    state_nx = IDLE;
                end
            end
            PEND: begin
                if (!icache_busy) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = merged.pc;
                    pend_nx        = '{cls: NONE, pc: '0};
                    state_nx       = RUN;
                end else begin
                    pend_nx = merged;
                end
            end
            IDLE: begin
                // Only an exception can wake with a redirect; branches just flush.
                if (win.cls == EXCP) begin
                    if (!icache_busy) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = win.pc;
                        state_nx       = RUN;
                    end else begin
                        pend_nx  = win;
                        state_nx = PEND;
                    end
                end else if (intr_pending) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = BOOT;
        endcase

        if (rst) begin
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            flush_front    = 1'b0;
            flush_back     = 1'b0;
            fetch_en       = 1'b0;
        end
    end

endmodule
